// File: rtl/sort_host_pkg.sv
// Shared types and constants for the sort_host accelerator driver.
// Imported by sort_host and axil_wr_pair.
package sort_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        POLL_AR,
        POLL_R,
        COLLECT,
        FIN
    } state_t;

    localparam int N_WORDS      = 10;
    localparam int IDX_W        = 4;
    localparam int AP_CTRL_ADDR = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int POLL_MAX     = 1024;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(N_WORDS);
    endfunction

endpackage

// File: rtl/axil_wr_pair.sv
// One AXI-Lite write of ap_start to the control register: address and data
// channels raise together and each drops after its own handshake.
module axil_wr_pair #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,
    output logic                   complete
);
    import sort_host_pkg::*;

    logic aw_pend;
    logic w_pend;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else if (start) begin
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
        end else begin
            if (aw_pend && awready) aw_pend <= 1'b0;
            if (w_pend && wready)   w_pend  <= 1'b0;
        end
    end

    assign awvalid = aw_pend;
    assign wvalid  = w_pend;

    // High in the cycle the last outstanding handshake happens, whichever channel it is.
    assign complete = (aw_pend | w_pend) & (~aw_pend | awready) & (~w_pend | wready);

    assign awaddr = pADDR_WIDTH'(AP_CTRL_ADDR);
    assign wdata  = rst ? '0 : pDATA_WIDTH'(1);

endmodule

// File: rtl/sort_host.sv
// Host-side driver for a 10-word stream sort accelerator: start, stream, poll, collect.
// Define SORT_HOST_TIMEOUT_EN to bound polling and report timeouts on err.
module sort_host #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   buf_we,
    input  logic [3:0]             buf_idx,
    input  logic [pDATA_WIDTH-1:0] buf_wdata,
    output logic [pDATA_WIDTH-1:0] buf_rdata,
    input  logic                   go,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rready,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tready
);
    import sort_host_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_WORDS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [pDATA_WIDTH-1:0] mem [N_WORDS];
    logic [IDX_W-1:0]       k;
    logic [IDX_W-1:0]       j;
    logic                   wr_start;
    logic                   wr_complete;
    logic                   host_wr;
    logic                   ss_hs;
    logic                   sm_hs;
    logic                   poll_expire;
    logic                   unused_status;

    assign busy      = (state != IDLE);
    assign wr_start  = (state == IDLE) && go;
    assign host_wr   = (state == IDLE) && buf_we && idx_ok(buf_idx);
    assign buf_rdata = idx_ok(buf_idx) ? mem[buf_idx] : '0;
    assign ss_tdata  = mem[k];
    assign araddr    = pADDR_WIDTH'(AP_CTRL_ADDR);
    assign ss_hs     = ss_tvalid && ss_tready;
    assign sm_hs     = sm_tready && sm_tvalid;

    // Only ap_done matters; the other status bits are intentionally ignored.
    assign unused_status = ^{rdata[pDATA_WIDTH-1:AP_DONE_BIT+1], rdata[AP_DONE_BIT-1:0]};

    axil_wr_pair #(
        .pADDR_WIDTH(pADDR_WIDTH),
        .pDATA_WIDTH(pDATA_WIDTH)
    ) u_wr (
        .clk     (axis_clk),
        .rst     (axis_rst),
        .start   (wr_start),
        .awvalid (awvalid),
        .awaddr  (awaddr),
        .awready (awready),
        .wvalid  (wvalid),
        .wdata   (wdata),
        .wready  (wready),
        .complete(wr_complete)
    );

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        sm_tready = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (go) state_nxt = START;
            end
            START: begin
                if (wr_complete) state_nxt = STREAM;
            end
            STREAM: begin
                ss_tvalid = 1'b1;
                ss_tlast  = (k == LAST);
                if (ss_tready && k == LAST) state_nxt = POLL_AR;
            end
            POLL_AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = POLL_R;
            end
            POLL_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (rdata[AP_DONE_BIT]) state_nxt = COLLECT;
                    else if (poll_expire)   state_nxt = FIN;
                    else                    state_nxt = POLL_AR;
                end
            end
            COLLECT: begin
                sm_tready = 1'b1;
                if (sm_tvalid && j == LAST) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            k <= '0;
            j <= '0;
        end else begin
            if (wr_start) begin
                k <= '0;
                j <= '0;
            end
            if (ss_hs) k <= (k == LAST) ? '0 : k + 1'b1;
            if (sm_hs) j <= (j == LAST) ? '0 : j + 1'b1;
        end
    end

    // NOTE: the buffer is reset word by word because it must read back as zero after axis_rst.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            for (int i = 0; i < N_WORDS; i++) mem[i] <= '0;
        end else if (host_wr) begin
            mem[buf_idx] <= buf_wdata;
        end else if (sm_hs) begin
            mem[j] <= sm_tdata;
        end
    end

`ifdef SORT_HOST_TIMEOUT_EN
    logic [15:0] poll_cnt;
    logic        err_q;

    assign poll_expire = (poll_cnt == 16'(POLL_MAX - 1));
    assign err         = err_q;

    // Counts completed polls that came back without ap_done.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            poll_cnt <= '0;
            err_q    <= 1'b0;
        end else if (wr_start) begin
            poll_cnt <= '0;
            err_q    <= 1'b0;
        end else if (rready && rvalid && !rdata[AP_DONE_BIT]) begin
            poll_cnt <= poll_cnt + 1'b1;
            if (poll_expire) err_q <= 1'b1;
        end
    end
`else
    assign poll_expire = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sort_host.sv
// Self-checking bench for sort_host with a behavioural accelerator/AXI-Lite responder.
// Reference model: the stream must equal the loaded words and the buffer must end up sorted.
module tb_sort_host;
    localparam int AW = 12;
    localparam int DW = 32;
    typedef logic [DW-1:0] word_arr_t [10];

    logic          axis_clk;
    logic          axis_rst;
    logic          buf_we;
    logic [3:0]    buf_idx;
    logic [DW-1:0] buf_wdata;
    logic [DW-1:0] buf_rdata;
    logic          go;
    logic          busy;
    logic          done;
    logic          err;
    logic          awvalid;
    logic [AW-1:0] awaddr;
    logic          awready;
    logic          wvalid;
    logic [DW-1:0] wdata;
    logic          wready;
    logic          arvalid;
    logic [AW-1:0] araddr;
    logic          arready;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          rready;
    logic          ss_tvalid;
    logic [DW-1:0] ss_tdata;
    logic          ss_tlast;
    logic          ss_tready;
    logic          sm_tvalid;
    logic [DW-1:0] sm_tdata;
    logic          sm_tready;

    int n_checks = 0;
    int n_fail   = 0;

    int aw_delay, w_delay, done_after;
    bit stall_mode, sm_gaps;
    int aw_hs, w_hs, ar_hs, r_hs, done_cnt, stall_err, proto_err, tlast_err;
    bit err_at_done;
    logic [DW-1:0] got_stream [$];
    logic [DW-1:0] ret_q [$];

    sort_host #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .buf_we(buf_we), .buf_idx(buf_idx), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .go(go), .busy(busy), .done(done), .err(err),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rready(rready),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tready(sm_tready)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic idle_inputs();
        go = 0; buf_we = 0; awready = 0; wready = 0; arready = 0; rvalid = 0;
        rdata = '0; ss_tready = 0; sm_tvalid = 0; sm_tdata = '0;
    endtask

    task automatic rand_words(output word_arr_t v);
        for (int i = 0; i < 10; i++) v[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 20)) : $urandom;
    endtask

    task automatic sort_words(input word_arr_t a, output word_arr_t s);
        logic [DW-1:0] q [$];
        for (int i = 0; i < 10; i++) q.push_back(a[i]);
        q.sort();
        for (int i = 0; i < 10; i++) s[i] = q[i];
    endtask

    function automatic int diff_words(input word_arr_t a, input word_arr_t b);
        int d = 0;
        for (int i = 0; i < 10; i++) if (a[i] !== b[i]) d++;
        return d;
    endfunction

    function automatic int diff_stream(input word_arr_t exp);
        int d = 0;
        if (got_stream.size() != 10) return 99;
        for (int i = 0; i < 10; i++) if (got_stream[i] !== exp[i]) d++;
        return d;
    endfunction

    task automatic load_buffer(input word_arr_t vals);
        for (int i = 0; i < 10; i++) begin
            @(negedge axis_clk);
            buf_we = 1; buf_idx = 4'(i); buf_wdata = vals[i];
        end
        @(negedge axis_clk);
        buf_we = 0;
    endtask

    task automatic read_buffer(output word_arr_t got);
        for (int i = 0; i < 10; i++) begin
            @(negedge axis_clk);
            buf_idx = 4'(i);
            #1 got[i] = buf_rdata;
        end
    endtask

    // Cycle-by-cycle model of the AXI-Lite slave and the sorting accelerator.
    task automatic run_responder(input int budget, input int abort_at, input bit poke, output bit finished);
        int aw_wait = 0;
        int w_wait = 0;
        int sm_idx = 0;
        bit tog = 0;
        bit held_valid = 0;
        bit poked_go = 0;
        bit poked_we = 0;
        logic [DW-1:0] held = '0;
        finished = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge axis_clk);
            go = 0; buf_we = 0;
            if (done) begin
                done_cnt++; err_at_done = err; idle_inputs(); finished = 1;
                return;
            end
            if (abort_at >= 0 && ss_tvalid && got_stream.size() == abort_at) begin
                idle_inputs(); finished = 1;
                return;
            end
            awready = 0;
            if (awvalid) begin
                if (aw_hs != 0 || awaddr !== '0) proto_err++;
                awready = (aw_wait >= aw_delay);
                aw_wait++;
                if (awready) aw_hs++;
            end
            wready = 0;
            if (wvalid) begin
                if (w_hs != 0 || wdata !== DW'(1)) proto_err++;
                wready = (w_wait >= w_delay);
                w_wait++;
                if (wready) w_hs++;
            end
            tog = ~tog;
            ss_tready = 0;
            if (held_valid && !ss_tvalid) stall_err++;
            if (ss_tvalid) begin
                if (held_valid && ss_tdata !== held) stall_err++;
                if (ss_tlast !== (got_stream.size() == 9)) tlast_err++;
                ss_tready = stall_mode ? tog : 1'b1;
                if (ss_tready) begin
                    got_stream.push_back(ss_tdata);
                    held_valid = 0;
                    if (got_stream.size() == 10) begin
                        ret_q = got_stream;
                        ret_q.sort();
                    end
                end else begin
                    held = ss_tdata; held_valid = 1;
                end
            end
            arready = arvalid;
            if (arvalid) begin
                if (araddr !== '0) proto_err++;
                ar_hs++;
            end
            rvalid = rready;
            rdata = '0;
            if (rready) begin
                rdata = (r_hs >= done_after) ? DW'(6) : DW'(1);
                r_hs++;
            end
            sm_tvalid = 0;
            sm_tdata = $urandom;
            if (sm_tready && sm_idx < ret_q.size()) begin
                sm_tvalid = sm_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (sm_tvalid) begin
                    sm_tdata = ret_q[sm_idx];
                    sm_idx++;
                    if (poke && !poked_we && sm_idx == 10) begin
                        buf_we = 1; buf_idx = 0; buf_wdata = 32'hDEAD_BEEF; poked_we = 1;
                    end
                end
            end
            if (poke && !poked_go && r_hs == 2) begin
                go = 1; poked_go = 1;
            end
        end
    endtask

    task automatic start_run(input int budget, input int abort_at, input bit poke, output bit finished);
        aw_hs = 0; w_hs = 0; ar_hs = 0; r_hs = 0; done_cnt = 0;
        stall_err = 0; proto_err = 0; tlast_err = 0; err_at_done = 0;
        got_stream.delete(); ret_q.delete();
        @(negedge axis_clk);
        go = 1;
        run_responder(budget, abort_at, poke, finished);
    endtask

    task automatic test_reset();
        idle_inputs();
        axis_rst = 1; buf_idx = 0; buf_wdata = '0;
        repeat (2) @(negedge axis_clk);
        n_checks++;
        if ({busy, done, err, awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready} !== 9'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 000000000",
                {busy, done, err, awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready});
        end
        n_checks++;
        if (ss_tdata !== '0 || wdata !== '0 || awaddr !== '0 || araddr !== '0 || buf_rdata !== '0) begin
            n_fail++; $display("FAIL reset_data: ss_tdata=%h wdata=%h awaddr=%h araddr=%h rdata=%h required all 0",
                ss_tdata, wdata, awaddr, araddr, buf_rdata);
        end
        @(negedge axis_clk);
        axis_rst = 0;
        repeat (2) @(negedge axis_clk);
        n_checks++;
        if (busy !== 0 || awvalid !== 0 || ss_tvalid !== 0) begin
            n_fail++; $display("FAIL reset_release_idle: busy=%b awvalid=%b ss_tvalid=%b required 0", busy, awvalid, ss_tvalid);
        end
    endtask

    task automatic test_readback();
        word_arr_t v, got;
        int bad = 0;
        rand_words(v);
        load_buffer(v);
        for (int i = 10; i < 16; i++) begin
            @(negedge axis_clk);
            buf_we = 1; buf_idx = 4'(i); buf_wdata = $urandom | 32'h1;
        end
        @(negedge axis_clk);
        buf_we = 0;
        read_buffer(got);
        n_checks++;
        if (diff_words(got, v) != 0) begin
            n_fail++; $display("FAIL readback: %0d words differ (word0 got %h required %h)", diff_words(got, v), got[0], v[0]);
        end
        for (int i = 10; i < 16; i++) begin
            @(negedge axis_clk);
            buf_idx = 4'(i);
            #1 if (buf_rdata !== '0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL readback_out_of_range: %0d nonzero reads required 0", bad);
        end
    endtask

    task automatic test_basic_run();
        word_arr_t v, s, got;
        bit fin;
        v = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd0, 32'd8, 32'd2, 32'd6, 32'd5, 32'd4};
        for (int i = 0; i < 10; i++) s[i] = DW'(i);
        aw_delay = 0; w_delay = 0; done_after = 0; stall_mode = 0; sm_gaps = 0;
        load_buffer(v);
        start_run(500, -1, 0, fin);
        n_checks++;
        if (!fin) begin n_fail++; $display("FAIL basic_timeout: done not seen within budget"); end
        n_checks++;
        if (aw_hs != 1 || w_hs != 1 || proto_err != 0) begin
            n_fail++; $display("FAIL basic_write: aw=%0d w=%0d proto_err=%0d required 1 1 0", aw_hs, w_hs, proto_err);
        end
        n_checks++;
        if (diff_stream(v) != 0 || tlast_err != 0) begin
            n_fail++; $display("FAIL basic_stream: diff=%0d tlast_err=%0d required 0 0", diff_stream(v), tlast_err);
        end
        n_checks++;
        if (r_hs != 1 || err_at_done !== 0) begin
            n_fail++; $display("FAIL basic_poll: reads=%0d err=%b required 1 0", r_hs, err_at_done);
        end
        @(negedge axis_clk);
        n_checks++;
        if (done !== 0 || busy !== 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL basic_done_pulse: done=%b busy=%b pulses=%0d required 0 0 1", done, busy, done_cnt);
        end
        read_buffer(got);
        n_checks++;
        if (diff_words(got, s) != 0) begin
            n_fail++; $display("FAIL basic_result: %0d words differ (word0 got %h required 0)", diff_words(got, s), got[0]);
        end
    endtask

    task automatic test_wr_skew();
        word_arr_t v, s, got;
        bit fin;
        int skew [3][2] = '{'{0, 1}, '{1, 0}, '{3, 0}};
        done_after = 0; stall_mode = 0; sm_gaps = 0;
        for (int t = 0; t < 3; t++) begin
            aw_delay = skew[t][0]; w_delay = skew[t][1];
            rand_words(v);
            sort_words(v, s);
            load_buffer(v);
            start_run(500, -1, 0, fin);
            n_checks++;
            if (!fin || aw_hs != 1 || w_hs != 1 || proto_err != 0) begin
                n_fail++; $display("FAIL wr_skew_%0d: fin=%b aw=%0d w=%0d proto_err=%0d required 1 1 1 0",
                    t, fin, aw_hs, w_hs, proto_err);
            end
            read_buffer(got);
            n_checks++;
            if (diff_words(got, s) != 0) begin
                n_fail++; $display("FAIL wr_skew_result_%0d: %0d words differ required 0", t, diff_words(got, s));
            end
        end
    endtask

    task automatic test_stall();
        word_arr_t v, s, got;
        bit fin;
        aw_delay = 0; w_delay = 0; done_after = 0; stall_mode = 1; sm_gaps = 0;
        rand_words(v);
        sort_words(v, s);
        load_buffer(v);
        start_run(500, -1, 0, fin);
        stall_mode = 0;
        n_checks++;
        if (!fin || stall_err != 0 || tlast_err != 0) begin
            n_fail++; $display("FAIL stall_hold: fin=%b stall_err=%0d tlast_err=%0d required 1 0 0", fin, stall_err, tlast_err);
        end
        n_checks++;
        if (diff_stream(v) != 0) begin
            n_fail++; $display("FAIL stall_order: diff=%0d required 0", diff_stream(v));
        end
        read_buffer(got);
        n_checks++;
        if (diff_words(got, s) != 0) begin
            n_fail++; $display("FAIL stall_result: %0d words differ required 0", diff_words(got, s));
        end
    endtask

    task automatic test_poll_delay();
        word_arr_t v, s, got;
        bit fin;
        aw_delay = 0; w_delay = 0; done_after = 5; stall_mode = 0; sm_gaps = 1;
        rand_words(v);
        sort_words(v, s);
        load_buffer(v);
        start_run(800, -1, 1, fin);
        n_checks++;
        if (!fin || ar_hs != 6 || r_hs != 6) begin
            n_fail++; $display("FAIL poll_count: fin=%b ar=%0d r=%0d required 1 6 6", fin, ar_hs, r_hs);
        end
        @(negedge axis_clk);
        n_checks++;
        if (done_cnt != 1 || aw_hs != 1 || got_stream.size() != 10 || busy !== 0) begin
            n_fail++; $display("FAIL poll_go_ignored: pulses=%0d aw=%0d words=%0d busy=%b required 1 1 10 0",
                done_cnt, aw_hs, got_stream.size(), busy);
        end
        read_buffer(got);
        n_checks++;
        if (diff_words(got, s) != 0) begin
            n_fail++; $display("FAIL poll_result: %0d words differ (word0 got %h required %h)", diff_words(got, s), got[0], s[0]);
        end
    endtask

    task automatic test_reset_mid_stream();
        word_arr_t v, got, z;
        bit fin;
        aw_delay = 0; w_delay = 0; done_after = 0; stall_mode = 0; sm_gaps = 0;
        for (int i = 0; i < 10; i++) z[i] = '0;
        rand_words(v);
        v[4] = v[4] | 32'h1;
        load_buffer(v);
        start_run(500, 4, 0, fin);
        axis_rst = 1;
        #1;
        n_checks++;
        if (!fin || {busy, done, awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready} !== 8'b0) begin
            n_fail++; $display("FAIL midrst_ctrl: fin=%b outs=%b required 1 00000000", fin,
                {busy, done, awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready});
        end
        n_checks++;
        if (ss_tdata !== '0 || got_stream.size() != 4) begin
            n_fail++; $display("FAIL midrst_tdata: ss_tdata=%h words=%0d required 0 4", ss_tdata, got_stream.size());
        end
        read_buffer(got);
        n_checks++;
        if (diff_words(got, z) != 0) begin
            n_fail++; $display("FAIL midrst_buffer: %0d nonzero words required 0", diff_words(got, z));
        end
        @(negedge axis_clk);
        axis_rst = 0;
        repeat (3) @(negedge axis_clk);
        n_checks++;
        if (busy !== 0 || ss_tvalid !== 0) begin
            n_fail++; $display("FAIL midrst_idle: busy=%b ss_tvalid=%b required 0 0", busy, ss_tvalid);
        end
    endtask

    task automatic test_back_to_back();
        word_arr_t v, s, got;
        bit fin;
        stall_mode = 0; sm_gaps = 1; done_after = 0;
        for (int r = 0; r < 2; r++) begin
            aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2);
            rand_words(v);
            sort_words(v, s);
            load_buffer(v);
            start_run(500, -1, 0, fin);
            n_checks++;
            if (!fin || diff_stream(v) != 0 || err_at_done !== 0) begin
                n_fail++; $display("FAIL b2b_stream_%0d: fin=%b diff=%0d err=%b required 1 0 0", r, fin, diff_stream(v), err_at_done);
            end
            repeat (3) @(negedge axis_clk);
            n_checks++;
            if (busy !== 0 || awvalid !== 0 || done !== 0) begin
                n_fail++; $display("FAIL b2b_needs_go_%0d: busy=%b awvalid=%b done=%b required 0 0 0", r, busy, awvalid, done);
            end
            read_buffer(got);
            n_checks++;
            if (diff_words(got, s) != 0) begin
                n_fail++; $display("FAIL b2b_result_%0d: %0d words differ required 0", r, diff_words(got, s));
            end
        end
        sm_gaps = 0;
    endtask

`ifdef SORT_HOST_TIMEOUT_EN
    task automatic test_timeout();
        word_arr_t v, got;
        bit fin;
        aw_delay = 0; w_delay = 0; done_after = 1 << 30; stall_mode = 0; sm_gaps = 0;
        rand_words(v);
        load_buffer(v);
        start_run(5000, -1, 0, fin);
        n_checks++;
        if (!fin || r_hs != 1024 || ar_hs != 1024 || err_at_done !== 1) begin
            n_fail++; $display("FAIL timeout_polls: fin=%b ar=%0d r=%0d err=%b required 1 1024 1024 1",
                fin, ar_hs, r_hs, err_at_done);
        end
        read_buffer(got);
        n_checks++;
        if (diff_words(got, v) != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL timeout_buffer: diff=%0d pulses=%0d required 0 1", diff_words(got, v), done_cnt);
        end
        done_after = 0;
        start_run(500, -1, 0, fin);
        n_checks++;
        if (!fin || err_at_done !== 0) begin
            n_fail++; $display("FAIL timeout_err_clear: fin=%b err=%b required 1 0", fin, err_at_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_readback();
        test_basic_run();
        test_wr_skew();
        test_stall();
        test_poll_delay();
        test_reset_mid_stream();
        test_back_to_back();
`ifdef SORT_HOST_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
